// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;

  localparam int AES128_ROUNDS = 10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_INIT_ADD = 3'd2,
    ST_SUB      = 3'd3,
    ST_SHIFT    = 3'd4,
    ST_MIX      = 3'd5,
    ST_ADD      = 3'd6,
    ST_DONE     = 3'd7
  } state_t;

endpackage

// File: rtl/aes_round_counter.sv
// Round index register: synchronous clear, saturating increment at NUM_ROUNDS.
module aes_round_counter #(
  parameter int NUM_ROUNDS = 10,
  parameter int RND_BITS   = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                inc,
  output logic [RND_BITS-1:0] count,
  output logic                last_round
);

  assign last_round = (count == RND_BITS'(NUM_ROUNDS));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !last_round) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: steps the datapath enables and key fetches
// for one block per start handshake and holds the result until the host takes it.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int RND_BITS   = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic                abort,
  input  logic                key_ready,
  output logic                key_req,
  output logic [RND_BITS-1:0] round_num,
  output logic                load_en,
  output logic                sub_en,
  output logic                shift_en,
  output logic                mix_en,
  output logic                addkey_en,
  output logic                busy,
  output logic                out_valid,
  input  logic                out_ready,
  output state_t              state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready (start_ready / out_valid are Moore).
  state_t state, state_nx;
  logic   cnt_clear, cnt_inc, last_round;

  aes_round_counter #(
    .NUM_ROUNDS(NUM_ROUNDS),
    .RND_BITS  (RND_BITS)
  ) u_round_counter (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (cnt_clear),
    .inc       (cnt_inc),
    .count     (round_num),
    .last_round(last_round)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    if (abort) begin
      state_nx  = ST_IDLE;
      cnt_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_valid) state_nx = ST_LOAD;
        end
        ST_LOAD: begin
          cnt_clear = 1'b1;
          state_nx  = ST_INIT_ADD;
        end
        ST_INIT_ADD: begin
          if (key_ready) begin
            cnt_inc  = 1'b1;
            state_nx = ST_SUB;
          end
        end
        ST_SUB:   state_nx = ST_SHIFT;
        ST_SHIFT: state_nx = last_round ? ST_ADD : ST_MIX;
        ST_MIX:   state_nx = ST_ADD;
        ST_ADD: begin
          if (key_ready) begin
            if (last_round) begin
              state_nx = ST_DONE;
            end else begin
              cnt_inc  = 1'b1;
              state_nx = ST_SUB;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            cnt_clear = 1'b1;
            state_nx  = ST_IDLE;
          end
        end
        default: begin
          cnt_clear = 1'b1;
          state_nx  = ST_IDLE;
        end
      endcase
    end
  end

  // The key add fires in the cycle the key arrives; an abort cancels it.
  assign key_req     = (state == ST_INIT_ADD) || (state == ST_ADD);
  assign addkey_en   = key_req && key_ready && !abort;
  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign load_en     = (state == ST_LOAD);
  assign sub_en      = (state == ST_SUB);
  assign shift_en    = (state == ST_SHIFT);
  assign mix_en      = (state == ST_MIX);
  assign out_valid   = (state == ST_DONE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: latency scoreboard plus enable counts,
// key stall, output backpressure, abort and mid-operation reset.
module tb_aes_round_ctrl;
  import aes_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start_valid, start_ready, abort, key_ready, key_req;
  logic [3:0]   round_num;
  logic         load_en, sub_en, shift_en, mix_en, addkey_en, busy;
  logic         out_valid, out_ready;
  state_t       state_dbg;

  int           vectors     = 0;
  int           miscompares = 0;
  logic [31:0]  exp_q[$];

  aes_round_ctrl #(.NUM_ROUNDS(10), .RND_BITS(4)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .abort      (abort),
    .key_ready  (key_ready),
    .key_req    (key_req),
    .round_num  (round_num),
    .load_en    (load_en),
    .sub_en     (sub_en),
    .shift_en   (shift_en),
    .mix_en     (mix_en),
    .addkey_en  (addkey_en),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] outs_active();
    return {load_en, sub_en, shift_en, mix_en, addkey_en, key_req, out_valid};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_outs"}, 32'(outs_active()), 32'd0);
    check({tag, "_round"}, 32'(round_num), 32'd0);
  endtask

  // driver: present one start and let the accepting edge pass
  task automatic start_block();
    @(negedge clk);
    check("start_ready_pre", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  task automatic run_until(input state_t st, input int rnd, output bit found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (state_dbg == st && int'(round_num) == rnd) found = 1'b1;
      n++;
    end
    if (!found) check("run_until_timeout", 32'd0, 32'd1);
  endtask

  // Full block with optional key stall in one ADD round and DONE backpressure.
  task automatic run_block(input int stall_rnd, input int stall_n, input int bp_n);
    int e, lat, stall_left, stall_seen, load_edge, prev_rnd, bad_rnd;
    int n_load, n_sub, n_shift, n_mix, n_add;
    bit done;
    e = 0; lat = 0; stall_left = stall_n; stall_seen = 0; load_edge = -1;
    prev_rnd = 0; bad_rnd = 0; done = 1'b0;
    n_load = 0; n_sub = 0; n_shift = 0; n_mix = 0; n_add = 0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    out_ready = (bp_n == 0);
    exp_q.push_back(32'(41 + stall_n));
    start_block();
    while (!done && e < 200) begin
      @(negedge clk);
      key_ready = 1'b1;
      if (state_dbg == ST_ADD && int'(round_num) == stall_rnd && stall_left > 0) begin
        key_ready = 1'b0;
        stall_left--;
      end
      #1;
      if (out_valid) begin
        done = 1'b1;
        lat  = e;
      end else begin
        n_load  += int'(load_en);
        n_sub   += int'(sub_en);
        n_shift += int'(shift_en);
        n_mix   += int'(mix_en);
        n_add   += int'(addkey_en);
        if (key_req && !key_ready && !addkey_en) stall_seen++;
        if (load_en) load_edge = e;
        if (int'(round_num) < prev_rnd || int'(round_num) > 10) bad_rnd++;
        prev_rnd = int'(round_num);
        @(posedge clk);
        e++;
      end
    end
    key_ready = 1'b1;
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      check("latency", 32'(lat), exp_q.pop_front());
      check("load_edge", 32'(load_edge), 32'd0);
      check("n_load", 32'(n_load), 32'd1);
      check("n_sub", 32'(n_sub), 32'd10);
      check("n_shift", 32'(n_shift), 32'd10);
      check("n_mix", 32'(n_mix), 32'd9);
      check("n_addkey", 32'(n_add), 32'd11);
      check("round_monotonic", 32'(bad_rnd), 32'd0);
      check("round_final", 32'(round_num), 32'd10);
      check("stall_cycles", 32'(stall_seen), 32'(stall_n));
      for (int i = 0; i < bp_n; i++) begin
        if (i > 0) @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_start_ready", 32'(start_ready), 32'd0);
        start_valid = (i == 2);
        if (i == bp_n - 1) out_ready = 1'b1;
        @(posedge clk);
      end
      start_valid = 1'b0;
      if (bp_n == 0) @(posedge clk);
      @(negedge clk);
      check_idle("post_done");
    end
    out_ready = 1'b1;
  endtask

  task automatic abort_test();
    bit found;
    logic [6:0] seen;
    start_block();
    run_until(ST_MIX, 5, found);
    if (found) begin
      check("abort_in_mix", 32'(mix_en), 32'd1);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      check_idle("post_abort");
      seen = '0;
      repeat (5) begin
        @(negedge clk);
        seen |= outs_active();
      end
      check("abort_quiet", 32'(seen), 32'd0);
    end
  endtask

  task automatic reset_test();
    bit found;
    logic [6:0] seen;
    start_block();
    run_until(ST_SHIFT, 7, found);
    if (found) begin
      n_rst = 1'b0;
      #1;
      check_idle("in_reset");
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      seen = '0;
      repeat (4) begin
        @(negedge clk);
        seen |= outs_active();
      end
      check("post_reset_quiet", 32'(seen), 32'd0);
      check_idle("post_reset");
    end
  endtask

  initial begin
    n_rst = 1'b0; start_valid = 1'b0; abort = 1'b0; key_ready = 1'b1; out_ready = 1'b1;
    #2;
    check_idle("reset");
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check_idle("idle");
    run_block(0, 0, 0);
    run_block(3, 5, 0);
    run_block(0, 0, 8);
    abort_test();
    run_block(0, 0, 0);
    run_block($urandom_range(1, 10), $urandom_range(1, 4), $urandom_range(3, 6));
    reset_test();
    run_block(0, 0, 0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
